// File: rtl/rfphoenix_dcache_repl.sv
// Data-cache replacement way selector: LFSR random, per-set round-robin or tree pseudo-LRU.
// Victim is registered one cycle after fill acceptance; fills stall only while the invalidate sweep runs.
module rfphoenix_dcache_repl #(
  parameter int WAYS = 4,
  parameter int SETS = 64,
  parameter int MODE = 2,
  localparam int W = $clog2(WAYS),
  localparam int S = $clog2(SETS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hit_v,
  input  logic [S-1:0] hit_set,
  input  logic [W-1:0] hit_way,
  input  logic         fill_req,
  input  logic [S-1:0] fill_set,
  output logic         fill_rdy,
  output logic [W-1:0] wway,
  output logic         wway_v,
  input  logic         inv_all,
  output logic         busy
);

  localparam int TW = WAYS - 1;
  localparam int SW = (MODE == 2) ? TW : W;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {ST_IDLE, ST_SWEEP} fsm_e;

  fsm_e          fsm_q;
  logic          start_q;
  logic [S-1:0]  sweep_q;
  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_d;
  logic [W-1:0]  wway_q;
  logic          wway_v_q;
  logic [SW-1:0] repl_mem [SETS];

  logic          fill_acc;
  logic          hit_acc;
  logic          hit_we;
  logic [TW-1:0] t_fill;
  logic [TW-1:0] t_hit;
  logic [W-1:0]  victim;
  logic [SW-1:0] fill_wdat;
  logic [SW-1:0] hit_wdat;

  // Heap-ordered tree: node n has children 2n+1 / 2n+2; the path bits spell the way index MSB first.
  function automatic logic [W-1:0] plru_victim(input logic [TW-1:0] t);
    int           node;
    logic         b;
    logic [W-1:0] v;
    node = 0;
    v    = '0;
    for (int l = W - 1; l >= 0; l--) begin
      b = 1'b0;
      for (int n = 0; n < TW; n++)
        if (n == node) b = t[n];
      v[l] = b;
      node = 2 * node + 1 + int'(b);
    end
    return v;
  endfunction

  function automatic logic [TW-1:0] plru_touch(input logic [TW-1:0] t, input logic [W-1:0] way);
    logic [TW-1:0] r;
    int            node;
    r    = t;
    node = 0;
    for (int l = W - 1; l >= 0; l--) begin
      for (int n = 0; n < TW; n++)
        if (n == node) r[n] = ~way[l];
      node = 2 * node + 1 + int'(way[l]);
    end
    return r;
  endfunction

  assign busy     = (fsm_q == ST_SWEEP);
  assign fill_rdy = ~busy;
  assign fill_acc = fill_req & ~busy;
  assign hit_acc  = hit_v & ~busy & (MODE == 2);
  // A fill to the same set supersedes the hit update.
  assign hit_we   = hit_acc & ~(fill_acc & (hit_set == fill_set));

  assign t_fill   = TW'(repl_mem[fill_set]);
  assign t_hit    = TW'(repl_mem[hit_set]);
  assign hit_wdat = SW'(plru_touch(t_hit, hit_way));

  always_comb begin
    victim    = '0;
    fill_wdat = '0;
    case (MODE)
      0: victim = lfsr_q[W-1:0];
      1: begin
        victim    = t_fill[W-1:0];
        fill_wdat = SW'(t_fill[W-1:0] + 1'b1);
      end
      default: begin
        victim    = plru_victim(t_fill);
        fill_wdat = SW'(plru_touch(t_fill, victim));
      end
    endcase
  end

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  // Per-set state is deliberately left unreset; the sweep that follows reset clears it.
  always_ff @(posedge clk) begin
    if (busy) begin
      repl_mem[sweep_q] <= '0;
    end else begin
      if (fill_acc && MODE != 0) repl_mem[fill_set] <= fill_wdat;
      if (hit_we) repl_mem[hit_set] <= hit_wdat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= ST_IDLE;
      start_q  <= 1'b1;
      sweep_q  <= '0;
      lfsr_q   <= LFSR_SEED;
      wway_q   <= '0;
      wway_v_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      start_q  <= 1'b0;
      wway_v_q <= fill_acc;
      if (fill_acc)     wway_q <= victim;
      else if (hit_acc) wway_q <= hit_way;
      if (inv_all || start_q) begin
        fsm_q   <= ST_SWEEP;
        sweep_q <= '0;
      end else if (fsm_q == ST_SWEEP) begin
        sweep_q <= sweep_q + 1'b1;
        if (sweep_q == S'(SETS - 1)) fsm_q <= ST_IDLE;
      end
    end
  end

  assign wway   = wway_q;
  assign wway_v = wway_v_q;

endmodule

// File: tb/tb_rfphoenix_dcache_repl.sv
// Bench for rfphoenix_dcache_repl: PLRU, round-robin and random instances checked against a behavioural model.
module tb_rfphoenix_dcache_repl;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic inv_all = 1'b0;
  always #5 clk = ~clk;

  // PLRU instance, 4 ways
  logic       h2_v = 1'b0;  logic [5:0] h2_set = '0; logic [1:0] h2_way = '0;
  logic       f2_req = 1'b0; logic [5:0] f2_set = '0;
  logic       f2_rdy, w2_v, b2; logic [1:0] w2;
  // round-robin instance, 8 ways
  logic       h1_v = 1'b0;  logic [5:0] h1_set = '0; logic [2:0] h1_way = '0;
  logic       f1_req = 1'b0; logic [5:0] f1_set = '0;
  logic       f1_rdy, w1_v, b1; logic [2:0] w1;
  // random instance, 4 ways, requests a fill every cycle
  logic       h0_v = 1'b0;  logic [5:0] h0_set = '0; logic [1:0] h0_way = '0;
  logic       f0_req = 1'b1; logic [5:0] f0_set = 6'd17;
  logic       f0_rdy, w0_v, b0; logic [1:0] w0;

  rfphoenix_dcache_repl #(.WAYS(4), .SETS(64), .MODE(2)) u_plru (
    .clk(clk), .rst(rst), .hit_v(h2_v), .hit_set(h2_set), .hit_way(h2_way),
    .fill_req(f2_req), .fill_set(f2_set), .fill_rdy(f2_rdy), .wway(w2), .wway_v(w2_v),
    .inv_all(inv_all), .busy(b2));
  rfphoenix_dcache_repl #(.WAYS(8), .SETS(64), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .hit_v(h1_v), .hit_set(h1_set), .hit_way(h1_way),
    .fill_req(f1_req), .fill_set(f1_set), .fill_rdy(f1_rdy), .wway(w1), .wway_v(w1_v),
    .inv_all(inv_all), .busy(b1));
  rfphoenix_dcache_repl #(.WAYS(4), .SETS(64), .MODE(0)) u_rnd (
    .clk(clk), .rst(rst), .hit_v(h0_v), .hit_set(h0_set), .hit_way(h0_way),
    .fill_req(f0_req), .fill_set(f0_set), .fill_rdy(f0_rdy), .wway(w0), .wway_v(w0_v),
    .inv_all(inv_all), .busy(b0));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_busy;
  bit          m_start;
  logic [15:0] m_lfsr;
  int          m_w[3];
  int          m_v[3];
  int          tr_root[64], tr_l[64], tr_r[64], ctr[64];
  bit          idle, a0, a1, a2;
  int          vic;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic        fb;
    logic [15:0] y;
    fb = x[0];
    y  = {fb, x[15:1]};
    y[13] = y[13] ^ fb;
    y[12] = y[12] ^ fb;
    y[10] = y[10] ^ fb;
    return y;
  endfunction

  function automatic int plru_vic(input int s);
    return (tr_root[s] != 0) ? 2 + tr_r[s] : tr_l[s];
  endfunction

  task automatic plru_touch(input int s, input int w);
    tr_root[s] = (w < 2) ? 1 : 0;
    if (w < 2) tr_l[s] = (w == 0) ? 1 : 0;
    else       tr_r[s] = (w == 2) ? 1 : 0;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_lfsr  = 16'hACE1;
      m_busy  = 0;
      m_start = 1'b1;
      for (int i = 0; i < 3; i++) begin m_w[i] = 0; m_v[i] = 0; end
    end else begin
      idle = (m_busy == 0);
      a2 = f2_req && idle;
      a1 = f1_req && idle;
      a0 = f0_req && idle;
      m_v[2] = int'(a2);
      if (a2) begin
        vic = plru_vic(int'(f2_set));
        m_w[2] = vic;
        plru_touch(int'(f2_set), vic);
      end
      if (h2_v && idle) begin
        if (!(a2 && h2_set == f2_set)) plru_touch(int'(h2_set), int'(h2_way));
        if (!a2) m_w[2] = int'(h2_way);
      end
      m_v[1] = int'(a1);
      if (a1) begin
        m_w[1] = ctr[f1_set];
        ctr[f1_set] = (ctr[f1_set] + 1) % 8;
      end
      m_v[0] = int'(a0);
      if (a0) m_w[0] = int'(m_lfsr % 16'd4);
      m_lfsr = lfsr_next(m_lfsr);
      if (inv_all || m_start) begin
        m_busy = 64;
        for (int s = 0; s < 64; s++) begin tr_root[s] = 0; tr_l[s] = 0; tr_r[s] = 0; ctr[s] = 0; end
      end else if (m_busy > 0) begin
        m_busy--;
      end
      m_start = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("plru_wway",  int'(w2),   m_w[2]);
      check("plru_wv",    int'(w2_v), m_v[2]);
      check("plru_busy",  int'(b2),   int'(m_busy > 0));
      check("plru_rdy",   int'(f2_rdy), int'(m_busy == 0));
      check("rr_wway",    int'(w1),   m_w[1]);
      check("rr_wv",      int'(w1_v), m_v[1]);
      check("rr_busy",    int'(b1),   int'(m_busy > 0));
      check("rnd_wway",   int'(w0),   m_w[0]);
      check("rnd_wv",     int'(w0_v), m_v[0]);
      check("rnd_busy",   int'(b0),   int'(m_busy > 0));
      check("rnd_rdy",    int'(f0_rdy), int'(m_busy == 0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (b2 && n < 200) begin n++; tick(); end
    check(name, n, 64);
  endtask

  int          exp4[4] = '{0, 2, 1, 3};
  logic [15:0] lx;
  int          n;

  initial begin
    lx = 16'hACE1;
    check("lfsr_step1", int'(lfsr_next(lx)), 16'hE270);
    for (int i = 0; i < 6; i++) lx = lfsr_next(lx);
    check("lfsr_step6", int'(lx), 16'hB313);

    tick();
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rdy_cycle0", int'(f2_rdy), 1);
    tick();
    check("rnd_first_wway", int'(w0), 1);
    check("rnd_first_v", int'(w0_v), 1);
    check("busy_after_rst", int'(b2), 1);
    count_busy("sweep_len_rst");

    // round-robin: nine fills to set 3 with ignored hits, then set 4
    f1_req = 1'b1; f1_set = 6'd3; h1_v = 1'b1; h1_set = 6'd3; h1_way = 3'd5;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr_set3_seq", int'(w1), (i == 8) ? 0 : i);
      check("rr_set3_v", int'(w1_v), 1);
    end
    f1_set = 6'd4;
    tick();
    check("rr_set4", int'(w1), 0);
    f1_req = 1'b0;
    tick();
    check("rr_hit_hold", int'(w1), 0);
    check("rr_hit_nov", int'(w1_v), 0);
    h1_v = 1'b0;

    // PLRU: four fills to a clean set
    f2_req = 1'b1; f2_set = 6'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("plru_seq", int'(w2), exp4[i]);
      check("plru_seq_v", int'(w2_v), 1);
    end
    f2_req = 1'b0; h2_v = 1'b1; h2_set = 6'd5; h2_way = 2'd0;
    tick();
    check("hit_load_wway", int'(w2), 0);
    check("hit_load_nov", int'(w2_v), 0);
    h2_v = 1'b0; f2_req = 1'b1;
    tick();
    check("plru_after_hit", int'(w2), 2);
    f2_req = 1'b0; h2_v = 1'b1; h2_set = 6'd9; h2_way = 2'd3;
    tick();
    check("hit_wway", int'(w2), 3);
    h2_v = 1'b0;

    // invalidate sweep with fills and hits arriving while busy
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    check("inv_busy", int'(b2), 1);
    f2_req = 1'b1; f2_set = 6'd6; h2_v = 1'b1; h2_set = 6'd10; h2_way = 2'd1;
    n = 0;
    while (b2 && n < 200) begin
      if (n == 3) h2_v = 1'b0;
      n++;
      tick();
      check("no_fill_busy", int'(w2_v), 0);
    end
    check("sweep_len_inv", n, 64);
    tick();
    check("fill_after_sweep", int'(w2), 0);
    check("fill_after_sweep_v", int'(w2_v), 1);
    f2_set = 6'd10;
    tick();
    check("hit_ignored_busy", int'(w2), 0);

    // same-set hit+fill: fill wins; different sets: both update
    f2_set = 6'd5; h2_v = 1'b1; h2_set = 6'd5; h2_way = 2'd2;
    tick();
    check("same_set_vic", int'(w2), 0);
    h2_v = 1'b0;
    tick();
    check("fill_wins", int'(w2), 2);
    f2_set = 6'd8; h2_v = 1'b1; h2_set = 6'd7; h2_way = 2'd0;
    tick();
    check("diff_set_fill", int'(w2), 0);
    h2_v = 1'b0; f2_set = 6'd7;
    tick();
    check("diff_set_hit", int'(w2), 2);
    f2_req = 1'b0;

    // reset in the middle of a sweep
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_busy", int'(b2), 0);
    check("rst_mid_rdy", int'(f2_rdy), 1);
    tick();
    rst = 1'b0;
    tick();
    count_busy("sweep_len_rst2");

    // reset one cycle after a fill is accepted
    f2_req = 1'b1; f2_set = 6'd5;
    tick();
    tick();
    check("pre_abort_wway", int'(w2), 2);
    f2_req = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_wv", int'(w2_v), 0);
    check("abort_wway", int'(w2), 0);
    tick();
    rst = 1'b0;
    tick();
    count_busy("sweep_len_abort");

    repeat (3) tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
